// File: rtl/div_unit.sv
// rtl/div_unit.sv - Multicycle signed radix-2 restoring divider for DIV (LO=quotient, HI=remainder)
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             DivOp,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_end,
   output logic             div_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic             w_start;
   logic             w_zero;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvsr;
   logic             r_sign_q;
   logic             r_sign_r;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic             r_div_end;
   logic             r_div_zero;

   logic [WIDTH-1:0] w_abs_a;
   logic [WIDTH-1:0] w_abs_b;
   logic [WIDTH+1:0] w_shifted;
   logic [WIDTH+1:0] w_trial;
   logic             w_ge;

   assign w_abs_a = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_abs_b = divisor[WIDTH-1]  ? -divisor  : divisor;

   // Remainder always stays below the divisor, so the shifted value fits WIDTH+1 bits;
   // the extra top bit of the trial acts as the borrow.
   assign w_shifted = {r_rem, r_quo[WIDTH-1]};
   assign w_trial   = w_shifted - {2'b00, r_dvsr};
   assign w_ge      = ~w_trial[WIDTH+1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      w_zero  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (DivOp) begin
               if (divisor == '0) begin
                  w_zero = 1'b1;
               end else begin
                  w_start = 1'b1;
                  w_next  = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_next = S_FIX;
            end
         end
         S_FIX: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvsr     <= '0;
         r_sign_q   <= 1'b0;
         r_sign_r   <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_div_end  <= 1'b0;
         r_div_zero <= 1'b0;
      end else begin
         r_div_end  <= 1'b0;
         r_div_zero <= w_zero;
         if (w_start) begin
            r_quo    <= w_abs_a;
            r_dvsr   <= w_abs_b;
            r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign_r <= dividend[WIDTH-1];
            r_rem    <= '0;
            r_cnt    <= '0;
         end
         if (r_state == S_CALC) begin
            r_rem <= w_ge ? w_trial[WIDTH:0] : w_shifted[WIDTH:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_FIX) begin
            r_lo      <= r_sign_q ? -r_quo : r_quo;
            r_hi      <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            r_div_end <= 1'b1;
         end
      end
   end

   assign hi       = r_hi;
   assign lo       = r_lo;
   assign div_end  = r_div_end;
   assign div_zero = r_div_zero;
   assign busy     = (r_state != S_IDLE);

endmodule
